key_disp: RTL



---
 rtl/key_disp.sv | 125 ++++++++++++
 1 files changed

// File: rtl/key_disp.sv
// Key-entry display: edge-detects scanner key events into a right-entry digit
// buffer and multiplexes it onto a 7-segment display. Optional: ERR_DISP_EN.
module key_disp #(
  parameter int NDIG    = 4,
  parameter bit COM_ACT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pls1k,
  input  logic            nkpls,
  input  logic [4:0]      nkv,
  output logic [6:0]      seg_out,
  output logic [NDIG-1:0] com_out,
  output logic [3:0]      ndig_val
);

  localparam int         IW    = $clog2(NDIG);
  localparam logic [4:0] BLANK = 5'h10;
  localparam logic [4:0] K_CLR = 5'd17;
  localparam logic [4:0] K_BS  = 5'd18;
`ifdef ERR_DISP_EN
  localparam logic [4:0] K_ERR = 5'd31;
`endif

  function automatic logic [6:0] seg_enc(input logic [4:0] e);
    logic [6:0] s;
    case (e[3:0])
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    if (e[4]) s = '0;
    return s;
  endfunction

  logic                 p0, p1, nkpls_d;
  logic                 tick, key_ev;
  logic [NDIG-1:0][4:0] dig_q, dig_n;   // entry 0 is the rightmost digit
  logic [3:0]           cnt_n;
  logic [3:0]           hex;
  logic [IW-1:0]        scan_idx;
  logic [6:0]           seg_n;
  logic [NDIG-1:0]      com_n;
`ifdef ERR_DISP_EN
  logic                 err_q, err_n;
`endif

  assign tick   = p0 & ~p1;
  assign key_ev = nkpls & ~nkpls_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    dig_n = dig_q;
    cnt_n = ndig_val;
    hex   = '0;
`ifdef ERR_DISP_EN
    err_n = err_q;
`endif
    if (key_ev) begin
`ifdef ERR_DISP_EN
      err_n = (nkv == K_ERR);
`endif
      if (nkv >= 5'd1 && nkv <= 5'd16) begin
        if (nkv == 5'd10)     hex = 4'h0;
        else if (nkv < 5'd10) hex = nkv[3:0];
        else                  hex = 4'(nkv - 5'd1);
        dig_n = {dig_q[NDIG-2:0], {1'b0, hex}};
        if (ndig_val != 4'(NDIG)) cnt_n = ndig_val + 4'd1;
      end else if (nkv == K_CLR) begin
        dig_n = {NDIG{BLANK}};
        cnt_n = '0;
      end else if (nkv == K_BS && ndig_val != 4'd0) begin
        dig_n = {BLANK, dig_q[NDIG-1:1]};
        cnt_n = ndig_val - 4'd1;
      end
    end
  end

  // Display uses pre-update buffer contents, so a same-cycle key shows next visit.
  always_comb begin
    seg_n           = seg_enc(dig_q[scan_idx]);
`ifdef ERR_DISP_EN
    if (err_q) seg_n = 7'h79;
`endif
    com_n           = {NDIG{~COM_ACT}};
    com_n[scan_idx] = COM_ACT;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  // NOTE: the digit buffer is a handful of flops, not a RAM, so it is reset
  // along with everything else to give a known blank display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0       <= 1'b0;
      p1       <= 1'b0;
      nkpls_d  <= 1'b0;
      dig_q    <= {NDIG{BLANK}};
      ndig_val <= '0;
      scan_idx <= '0;
      seg_out  <= '0;
      com_out  <= {NDIG{~COM_ACT}};
`ifdef ERR_DISP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      p0       <= pls1k;
      p1       <= p0;
      nkpls_d  <= nkpls;
      dig_q    <= dig_n;
      ndig_val <= cnt_n;
`ifdef ERR_DISP_EN
      err_q    <= err_n;
`endif
      if (tick) begin
        seg_out  <= seg_n;
        com_out  <= com_n;
        scan_idx <= (scan_idx == IW'(NDIG - 1)) ? '0 : scan_idx + 1'b1;
      end
    end
  end

endmodule
